// File: rtl/apb4_burst_master.sv
// APB4 burst master: turns a burst command and write-data stream into APB transfers to
// address-decoded slaves, returning per-beat read responses and one write completion per burst.
//
// state  | meaning
// IDLE   | waiting for a burst command
// WDAT   | waiting for the write data of the next beat
// SETUP  | APB setup phase, or local DECERR if no slave decodes the address
// ACCESS | APB access phase, waiting for pready or the beat timeout
// RRESP  | read beat response held until accepted
// BRESP  | write burst completion held until accepted
module apb4_burst_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 2,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {32'h0002_F000, 32'h0001_F000},
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000},
   parameter int LEN_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr,
   input  logic [LEN_WIDTH-1:0]             cmd_len,
   input  logic [2:0]                       cmd_prot,
   input  logic                             wdat_valid,
   output logic                             wdat_ready,
   input  logic [DATA_WIDTH-1:0]            wdat_data,
   input  logic [DATA_WIDTH/8-1:0]          wdat_strb,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic [1:0]                       rsp_resp,
   output logic                             rsp_last,
   output logic                             bresp_valid,
   input  logic                             bresp_ready,
   output logic [1:0]                       bresp_resp,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic [NUM_SLAVES-1:0]            psel,
   output logic                             penable,
   output logic                             pwrite,
   output logic [DATA_WIDTH-1:0]            pwdata,
   output logic [DATA_WIDTH/8-1:0]          pstrb,
   output logic [2:0]                       pprot,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]            pready,
   input  logic [NUM_SLAVES-1:0]            pslverr
);

   typedef enum logic [2:0] {
      S_IDLE, S_WDAT, S_SETUP, S_ACCESS, S_RRESP, S_BRESP
   } state_t;

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 2);
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(STRB_W);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_beat;
   logic                  r_write;
   logic [2:0]            r_prot;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]     r_strb;
   logic [1:0]            r_err;
   logic [TMO_W-1:0]      r_tmo;

   logic                  w_hit;
   logic [SEL_W-1:0]      w_sel;
   logic                  w_pready;
   logic                  w_pslverr;
   logic [DATA_WIDTH-1:0] w_prdata;
   logic                  w_tmo_hit;
   logic                  w_last;
   logic                  w_done;
   logic [1:0]            w_resp;
   logic [1:0]            w_err_next;
   logic [DATA_WIDTH-1:0] w_rdata;

   // Descending scan so the lowest-index matching window is the one that sticks.
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((r_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
             SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            w_hit = 1'b1;
            w_sel = SEL_W'(i);
         end
      end
   end

   always_comb begin
      w_pready  = 1'b0;
      w_pslverr = 1'b0;
      w_prdata  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (w_sel == SEL_W'(i)) begin
            w_pready  = pready[i];
            w_pslverr = pslverr[i];
            w_prdata  = prdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_tmo_hit = TMO_EN && (r_tmo == TMO_LAST);
   assign w_last    = (r_beat == r_len);

   // A beat ends on a decode miss, on pready, or when the access budget runs out.
   always_comb begin
      w_done  = 1'b0;
      w_resp  = RESP_OKAY;
      w_rdata = '0;
      case (r_state)
         S_SETUP: begin
            if (!w_hit) begin
               w_done = 1'b1;
               w_resp = RESP_DECERR;
            end
         end
         S_ACCESS: begin
            if (w_pready) begin
               w_done  = 1'b1;
               w_resp  = w_pslverr ? RESP_SLVERR : RESP_OKAY;
               w_rdata = w_prdata;
            end else if (w_tmo_hit) begin
               w_done = 1'b1;
               w_resp = RESP_SLVERR;
            end
         end
         default: ;
      endcase
      w_err_next = (w_resp > r_err) ? w_resp : r_err;
   end

   assign cmd_ready  = (r_state == S_IDLE);
   assign wdat_ready = (r_state == S_WDAT);
   assign penable    = (r_state == S_ACCESS);
   assign paddr      = r_addr;
   assign pwrite     = r_write;
   assign pwdata     = r_wdata;
   assign pstrb      = r_write ? r_strb : '0;
   assign pprot      = r_prot;

   always_comb begin
      psel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         psel[i] = ((r_state == S_SETUP) || (r_state == S_ACCESS)) && w_hit &&
                   (w_sel == SEL_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_len       <= '0;
         r_beat      <= '0;
         r_write     <= 1'b0;
         r_prot      <= '0;
         r_wdata     <= '0;
         r_strb      <= '0;
         r_err       <= RESP_OKAY;
         r_tmo       <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_resp    <= RESP_OKAY;
         rsp_last    <= 1'b0;
         bresp_valid <= 1'b0;
         bresp_resp  <= RESP_OKAY;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr  <= cmd_addr;
                  r_len   <= cmd_len;
                  r_write <= cmd_write;
                  r_prot  <= cmd_prot;
                  r_beat  <= '0;
                  r_err   <= RESP_OKAY;
                  r_state <= cmd_write ? S_WDAT : S_SETUP;
               end
            end
            S_WDAT: begin
               if (wdat_valid) begin
                  r_wdata <= wdat_data;
                  r_strb  <= wdat_strb;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_tmo <= '0;
               if (w_hit) r_state <= S_ACCESS;
            end
            S_ACCESS: r_tmo <= r_tmo + 1'b1;
            S_RRESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (rsp_last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_addr  <= r_addr + ADDR_INC;
                     r_beat  <= r_beat + 1'b1;
                     r_state <= S_SETUP;
                  end
               end
            end
            S_BRESP: begin
               if (bresp_ready) begin
                  bresp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Beat completion overrides the per-state next state above.
         if (w_done) begin
            if (!r_write) begin
               rsp_valid <= 1'b1;
               rsp_data  <= w_rdata;
               rsp_resp  <= w_resp;
               rsp_last  <= w_last;
               r_state   <= S_RRESP;
            end else begin
               r_err <= w_err_next;
               if (w_last) begin
                  bresp_valid <= 1'b1;
                  bresp_resp  <= w_err_next;
                  r_state     <= S_BRESP;
               end else begin
                  r_addr  <= r_addr + ADDR_INC;
                  r_beat  <= r_beat + 1'b1;
                  r_state <= S_WDAT;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_apb4_burst_master.sv
// Scoreboard bench for apb4_burst_master: directed bursts against a two-slave APB model,
// with expected read beats, write completions and APB transfers checked by negedge monitors.
module tb_apb4_burst_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 2;
   localparam int LW = 4;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   logic cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic [2:0] cmd_prot;
   logic wdat_valid, wdat_ready;
   logic [DW-1:0] wdat_data;
   logic [SW-1:0] wdat_strb;
   logic rsp_valid, rsp_ready, rsp_last;
   logic [DW-1:0] rsp_data;
   logic [1:0] rsp_resp;
   logic bresp_valid, bresp_ready;
   logic [1:0] bresp_resp;
   logic [AW-1:0] paddr;
   logic [NS-1:0] psel;
   logic penable, pwrite;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [2:0] pprot;
   logic [NS*DW-1:0] prdata;
   logic [NS-1:0] pready, pslverr;

   always #5 clk = ~clk;

   apb4_burst_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_prot(cmd_prot),
      .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
      .wdat_strb(wdat_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .rsp_last(rsp_last),
      .bresp_valid(bresp_valid), .bresp_ready(bresp_ready), .bresp_resp(bresp_resp),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      bit          chk_data;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  sel;
      logic        wr;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [31:0] wdata;
   } apb_t;

   rsp_t       q_rsp[$];
   logic [1:0] q_b[$];
   apb_t       q_apb[$];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [127:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got %0h with nothing expected", name, act);
   endtask

   task automatic exp_rsp(input logic [31:0] d, input logic [1:0] r, input logic l, input bit c);
      rsp_t e;
      e.data = d; e.resp = r; e.last = l; e.chk_data = c;
      q_rsp.push_back(e);
   endtask

   task automatic exp_apb(input logic [31:0] a, input logic [1:0] s, input logic w,
                          input logic [3:0] st, input logic [2:0] p, input logic [31:0] wd);
      apb_t e;
      e.addr = a; e.sel = s; e.wr = w; e.strb = st; e.prot = p; e.wdata = wd;
      q_apb.push_back(e);
   endtask

   // Two-slave model: wait states or hang per slave, read data = paddr ^ rd_xor[i].
   int          acc_cnt[NS];
   int          wait_st[NS];
   bit          hang[NS];
   logic [31:0] rd_xor[NS];
   logic [31:0] err_addr;

   always_comb begin
      pready  = '0;
      pslverr = '0;
      prdata  = '0;
      for (int i = 0; i < NS; i++) begin
         pready[i]  = psel[i] && penable && !hang[i] && (acc_cnt[i] >= wait_st[i]);
         pslverr[i] = psel[i] && (paddr == err_addr);
         prdata[i*DW +: DW] = paddr ^ rd_xor[i];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NS; i++)
         acc_cnt[i] <= (psel[i] && penable && !pready[i]) ? acc_cnt[i] + 1 : 0;
   end

   // Monitors: pop and compare whenever the DUT completes a handshake.
   rsp_t       m_r;
   apb_t       m_a;
   logic [1:0] m_b;
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid && rsp_ready) begin
            if (q_rsp.size() == 0) unexpected("rsp_unexpected", {rsp_resp, rsp_data});
            else begin
               m_r = q_rsp.pop_front();
               chk("rsp_resp", rsp_resp, m_r.resp);
               chk("rsp_last", rsp_last, m_r.last);
               if (m_r.chk_data) chk("rsp_data", rsp_data, m_r.data);
            end
         end
         if (bresp_valid && bresp_ready) begin
            if (q_b.size() == 0) unexpected("bresp_unexpected", bresp_resp);
            else begin
               m_b = q_b.pop_front();
               chk("bresp_resp", bresp_resp, m_b);
            end
         end
         if (penable && ((psel & pready) != '0)) begin
            if (q_apb.size() == 0) unexpected("apb_unexpected", {paddr, psel});
            else begin
               m_a = q_apb.pop_front();
               chk("apb_xfer", {paddr, psel, pwrite, pstrb, pprot, (pwrite ? pwdata : 32'h0)},
                   {m_a.addr, m_a.sel, m_a.wr, m_a.strb, m_a.prot, m_a.wdata});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] p);
      int n = 0;
      while (!cmd_ready && n < 200) begin tick(); n++; end
      chk("cmd_ready_wait", (n < 200), 1'b1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_prot = p;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic send_wdat(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      wdat_valid = 1'b1; wdat_data = d; wdat_strb = s;
      while (!wdat_ready && n < 200) begin tick(); n++; end
      if (!wdat_ready) chk("wdat_ready_wait", wdat_ready, 1'b1);
      tick();
      wdat_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(cmd_ready && q_rsp.size() == 0 && q_b.size() == 0 && q_apb.size() == 0)
             && n < 500) begin
         tick(); n++;
      end
      chk({name, "_drained"}, (n < 500), 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  n;
      int  cnt;
      bit  seen;
      rst = 1'b1;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_prot = 0;
      wdat_valid = 0; wdat_data = 0; wdat_strb = 0;
      rsp_ready = 1'b1; bresp_ready = 1'b1;
      for (int i = 0; i < NS; i++) begin wait_st[i] = 0; hang[i] = 0; acc_cnt[i] = 0; end
      rd_xor[0] = 32'hA5A4_F011;
      rd_xor[1] = 32'h5A5A_0000;
      err_addr  = 32'hFFFF_FFFF;
      repeat (3) tick();

      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_ctrl", {psel, penable, wdat_ready, rsp_valid, bresp_valid}, 6'b0);
      chk("rst_apb", {paddr, pwdata, pstrb, pprot, pwrite}, 72'b0);
      chk("rst_rsp", {rsp_data, rsp_resp, rsp_last, bresp_resp}, 37'b0);
      rst = 1'b0;
      tick();

      // Single zero-wait read with latency checks.
      exp_rsp(32'hA5A5_0001, 2'b00, 1'b1, 1'b1);
      exp_apb(32'h0001_F010, 2'b01, 1'b0, 4'b0000, 3'b010, 32'h0);
      send_cmd(1'b0, 32'h0001_F010, 4'd0, 3'b010);
      @(negedge clk); chk("t1_setup", {psel, penable}, 3'b010);
      @(negedge clk); chk("t1_access", {psel, penable}, 3'b011);
      @(negedge clk); chk("t1_rsp_valid", rsp_valid, 1'b1);
      wait_idle("t1");

      // Four-beat write, two wait states per beat on slave 1.
      wait_st[1] = 2;
      exp_apb(32'h0002_F000, 2'b10, 1'b1, 4'b0011, 3'b101, 32'h1111_0000);
      exp_apb(32'h0002_F004, 2'b10, 1'b1, 4'b0011, 3'b101, 32'h1111_0001);
      exp_apb(32'h0002_F008, 2'b10, 1'b1, 4'b0011, 3'b101, 32'h1111_0002);
      exp_apb(32'h0002_F00C, 2'b10, 1'b1, 4'b0011, 3'b101, 32'h1111_0003);
      q_b.push_back(2'b00);
      send_cmd(1'b1, 32'h0002_F000, 4'd3, 3'b101);
      send_wdat(32'h1111_0000, 4'b0011);
      send_wdat(32'h1111_0001, 4'b0011);
      send_wdat(32'h1111_0002, 4'b0011);
      send_wdat(32'h1111_0003, 4'b0011);
      wait_idle("t2");
      wait_st[1] = 0;

      // Unmapped read: no select, DECERR two cycles after the handshake.
      exp_rsp(32'h0, 2'b11, 1'b1, 1'b0);
      send_cmd(1'b0, 32'h0003_0000, 4'd0, 3'b000);
      @(negedge clk); chk("t3_no_psel", {psel, penable}, 3'b000);
      @(negedge clk); chk("t3_decerr", {rsp_valid, rsp_resp}, 3'b111);
      wait_idle("t3");

      // Write burst running off the end of slave 0 into unmapped space.
      exp_apb(32'h0001_FFFC, 2'b01, 1'b1, 4'b1111, 3'b000, 32'hCAFE_0000);
      q_b.push_back(2'b11);
      send_cmd(1'b1, 32'h0001_FFFC, 4'd1, 3'b000);
      send_wdat(32'hCAFE_0000, 4'b1111);
      send_wdat(32'hCAFE_0001, 4'b1111);
      wait_idle("t3b");

      // Slave 1 never ready: 16 access cycles then SLVERR.
      hang[1] = 1'b1;
      exp_rsp(32'h0, 2'b10, 1'b1, 1'b0);
      send_cmd(1'b0, 32'h0002_F020, 4'd0, 3'b000);
      n = 0;
      while (!penable && n < 10) begin @(negedge clk); n++; end
      cnt = 0;
      while (penable && cnt < 40) begin cnt++; @(negedge clk); end
      chk("t4_penable_cycles", cnt, 16);
      chk("t4_released", {psel, penable}, 3'b000);
      wait_idle("t4");
      hang[1] = 1'b0;

      // Following write proceeds normally; completion at T+4.
      exp_apb(32'h0002_F010, 2'b10, 1'b1, 4'b1100, 3'b001, 32'hBEEF_0010);
      q_b.push_back(2'b00);
      send_cmd(1'b1, 32'h0002_F010, 4'd0, 3'b001);
      send_wdat(32'hBEEF_0010, 4'b1100);
      @(negedge clk); chk("t4_wr_setup", {psel, penable}, 3'b100);
      @(negedge clk);
      @(negedge clk); chk("t4_wr_bresp_latency", bresp_valid, 1'b1);
      wait_idle("t4b");

      // Three-beat read, consumer stalls on beat 1, slave error on beat 2.
      err_addr = 32'h0001_F108;
      exp_rsp(32'hA5A5_0111, 2'b00, 1'b0, 1'b1);
      exp_rsp(32'hA5A5_0115, 2'b00, 1'b0, 1'b1);
      exp_rsp(32'hA5A5_0119, 2'b10, 1'b1, 1'b1);
      exp_apb(32'h0001_F100, 2'b01, 1'b0, 4'b0000, 3'b011, 32'h0);
      exp_apb(32'h0001_F104, 2'b01, 1'b0, 4'b0000, 3'b011, 32'h0);
      exp_apb(32'h0001_F108, 2'b01, 1'b0, 4'b0000, 3'b011, 32'h0);
      send_cmd(1'b0, 32'h0001_F100, 4'd2, 3'b011);
      n = 0;
      while (!(rsp_valid && rsp_ready) && n < 20) begin @(negedge clk); n++; end
      tick();
      rsp_ready = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("t5_stall_apb_idle", {psel, penable}, 3'b000);
         chk("t5_stall_data", {rsp_valid, rsp_data, rsp_last}, {1'b1, 32'hA5A5_0115, 1'b0});
      end
      tick();
      rsp_ready = 1'b1;
      wait_idle("t5");
      err_addr = 32'hFFFF_FFFF;

      // Reset during the access phase of beat 1 of a four-beat write.
      wait_st[0] = 3;
      exp_apb(32'h0001_F200, 2'b01, 1'b1, 4'b1111, 3'b000, 32'h7777_0000);
      send_cmd(1'b1, 32'h0001_F200, 4'd3, 3'b000);
      send_wdat(32'h7777_0000, 4'b1111);
      send_wdat(32'h7777_0001, 4'b1111);
      n = 0;
      while (!penable && n < 20) begin @(negedge clk); n++; end
      tick();
      rst = 1'b1;
      tick();
      chk("t6_after_rst", {psel, penable, cmd_ready}, 4'b0001);
      rst = 1'b0;
      q_apb.delete();
      seen = 1'b0;
      repeat (20) begin tick(); seen = seen | bresp_valid; end
      chk("t6_no_bresp", seen, 1'b0);
      wait_st[0] = 0;

      // Recovery read on slave 1.
      exp_rsp(32'h5A58_F008, 2'b00, 1'b1, 1'b1);
      exp_apb(32'h0002_F008, 2'b10, 1'b0, 4'b0000, 3'b000, 32'h0);
      send_cmd(1'b0, 32'h0002_F008, 4'd0, 3'b000);
      wait_idle("t7");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb4_burst_master.md
Name: apb4_burst_master

Overview:
- Parametrised next-generation APB master engine, sitting between the AXI-side front end and the APB peripheral fabric.
- Accepts a burst command, a write-data stream, and returns read-beat and write-completion responses.
- Generalises the previous handler in several ways:
  - N slaves decoded by parameter base/mask instead of fixed windows.
  - APB4 PSTRB/PPROT support.
  - Local DECERR for unmapped addresses.
  - Per-beat access timeout.
  - Valid/ready backpressure on every internal stream.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, APB data width (32 or 64); byte increment per beat = DATA_WIDTH/8.
- NUM_SLAVES, 2, number of PSEL lines (1..16).
- SLV_BASE, {32'h0002_F000, 32'h0001_F000}, packed NUM_SLAVES×ADDR_WIDTH base addresses; slave i in slice i.
- SLV_MASK, {32'hFFFF_F000, 32'hFFFF_F000}, packed masks; hit_i = (addr & MASK_i) == BASE_i.
- LEN_WIDTH, 4, burst length field width.
- TIMEOUT_CYCLES, 16, max ACCESS cycles per beat; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  first beat address
- cmd_len  in  LEN_WIDTH  beats minus 1
- cmd_prot  in  3  PPROT value for the whole burst
- wdat_valid  in  1  write beat valid
- wdat_ready  out  1  write beat accepted
- wdat_data  in  DATA_WIDTH  write data
- wdat_strb  in  DATA_WIDTH/8  byte strobes
- rsp_valid  out  1  read beat response valid
- rsp_ready  in  1  read beat accepted
- rsp_data  out  DATA_WIDTH  read data
- rsp_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rsp_last  out  1  final beat of burst
- bresp_valid  out  1  write burst done
- bresp_ready  in  1  write completion accepted
- bresp_resp  out  2  worst response of the burst (priority 11>10>00)
- paddr  out  ADDR_WIDTH  APB address
- psel  out  NUM_SLAVES  one-hot select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes; 0 on reads
- pprot  out  3  APB protection
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i in slice i
- pready  in  NUM_SLAVES  per-slave ready
- pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- All state and outputs are registered or decoded from registered state. rst is sampled on posedge clk only.
- Reset state:
  - FSM = IDLE.
  - All valid, psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_*, bresp_* outputs = 0.
  - cmd_ready = 1.
- Reset asserted mid-burst aborts the burst: psel/penable are 0 the cycle after reset is sampled, and no response is issued.
- States: IDLE, WDAT, SETUP, ACCESS, RRESP, BRESP.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch addr/len/write/prot, beat_cnt=0, err_acc=00.
  - Next state: WDAT if write, else SETUP.
- WDAT:
  - wdat_ready = 1.
  - On handshake, latch data/strb, then go to SETUP.
  - Stall indefinitely while wdat_valid = 0.
- SETUP:
  - Decode addr; the lowest-index hit wins.
  - On hit: psel[i] = 1, penable = 0, paddr/pwrite/pwdata/pstrb/pprot valid; next state ACCESS.
  - On miss: psel = 0, no APB transfer; the beat completes with 11 next cycle.
- ACCESS:
  - psel held, penable = 1, tmo_cnt increments each cycle.
  - Beat completes on pready[sel]; resp = pslverr[sel] ? 10 : 00; read data = prdata slice[sel].
  - If TIMEOUT_CYCLES ≠ 0 and tmo_cnt reaches TIMEOUT_CYCLES without pready, the beat completes with 10 and psel/penable drop.
- Beat completion:
  - Read: go to RRESP with rsp_valid = 1 and rsp_last = (beat_cnt == len).
  - Write: err_acc = max(err_acc, resp). If beat_cnt == len, go to BRESP; else addr += DATA_WIDTH/8, beat_cnt++, go to WDAT.
- RRESP:
  - rsp_* held stable until rsp_ready.
  - Then, if last, go to IDLE; else increment addr/beat_cnt and go to SETUP.
- BRESP: bresp_valid/bresp_resp held until bresp_ready, then go to IDLE.
- Errors never terminate a burst early; all len+1 beats are issued.
- Address increments modulo 2^ADDR_WIDTH. Each beat is decoded independently, so a burst crossing a window boundary may change psel or hit DECERR mid-burst.
- psel/penable are 0 between beats for at least the IDLE/WDAT/RRESP cycles; APB back-to-back SETUP is not used.
- Latency with a zero-wait slave and a ready consumer:
  - Read beat: cmd handshake at T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3.
  - Write beat: wdat handshake at T+1, SETUP at T+2, ACCESS at T+3, bresp_valid at T+4.

Test Plan:
- Single read at 0x0001_F010, slave0 zero-wait, prdata=0xA5A5_0001 -> psel=01 at T+1, penable at T+2, rsp_valid at T+3 with data 0xA5A5_0001, resp 00, last=1.
- Write burst len=3 at 0x0002_F000, strb=4'b0011, slave1 inserts 2 wait states per beat -> paddr sequence 0x2F000/4/8/C, pstrb=0011, pprot=cmd_prot, single bresp 00.
- Read at 0x0003_0000 (unmapped) -> psel never asserted, rsp_resp=11 two cycles after the cmd handshake; then a write burst of len=1 starting at 0x0001_FFFC -> beat 0 OKAY, beat 1 at 0x0002_0000 DECERR, bresp=11.
- Slave never asserts pready, TIMEOUT_CYCLES=16 -> penable high for exactly 16 cycles, then psel/penable=0 and resp=10; the next command proceeds normally.
- Read burst len=2 with rsp_ready low for 5 cycles on beat 1 and pslverr on beat 2 -> no APB activity while stalled, rsp data stable, beat 2 resp=10, last only on beat 2.
- rst asserted during ACCESS of beat 1 of a 4-beat write -> next cycle psel=0, penable=0, cmd_ready=1, bresp_valid never asserted.
